// File: rtl/pmem_if.sv
// Line-level memory bus between the L2 cache (master) and the backing
// memory (slave): held read/write request, 32-bit byte address, 256-bit
// line, single-cycle completion pulse.
interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency line memory that answers the L2 cache's pmem requests.
// A request is captured in IDLE, counted down in BUSY and completed with
// a one-cycle resp in RESP. The line store itself has no reset; everything
// else (FSM, rdata, error flag, counters) clears asynchronously.
module pmem_responder #(
  parameter int IDX_BITS  = 8,
  parameter int READ_LAT  = 10,
  parameter int WRITE_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  pmem_if.slave       bus,
  output logic        protocol_error,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int LINES   = 2 ** IDX_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_BITS-1:0] idx_reg, idx_next;
  logic [255:0]        wdata_reg, wdata_next;
  logic                op_wr_reg, op_wr_next;
  logic                enter_resp;
  logic                both_req;

  logic [255:0] mem [LINES];

  // Offset and aliased upper address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.pmem_addr[4:0], bus.pmem_addr[31:5+IDX_BITS]};

  // The counter is loaded with the full latency and RESP is entered on the
  // edge where it reads 1, so with acceptance at edge 0 the resp cycle sits
  // between edges LAT and LAT+1 (LAT=1 therefore still spends one BUSY cycle).
  assign enter_resp = (state_reg == BUSY) && (cnt_reg == CNT_W'(1));

  // Next-state logic: capture operands on acceptance, count down in BUSY.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    op_wr_next = op_wr_reg;
    both_req   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.pmem_write) begin
          state_next = BUSY;
          cnt_next   = CNT_W'(WRITE_LAT);
          idx_next   = bus.pmem_addr[5 +: IDX_BITS];
          wdata_next = bus.pmem_wdata;
          op_wr_next = 1'b1;
          both_req   = bus.pmem_read;  // write wins, flag the conflict
        end else if (bus.pmem_read) begin
          state_next = BUSY;
          cnt_next   = CNT_W'(READ_LAT);
          idx_next   = bus.pmem_addr[5 +: IDX_BITS];
          op_wr_next = 1'b0;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = RESP;
      end
      RESP:    state_next = IDLE;  // requests still held here are not re-accepted
      default: state_next = IDLE;
    endcase
  end

  // State, captured operands, response outputs, error flag and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      wdata_reg      <= '0;
      op_wr_reg      <= 1'b0;
      bus.pmem_resp  <= 1'b0;
      bus.pmem_rdata <= '0;
      protocol_error <= 1'b0;
      read_count     <= '0;
      write_count    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      wdata_reg     <= wdata_next;
      op_wr_reg     <= op_wr_next;
      bus.pmem_resp <= enter_resp;
      if (both_req) protocol_error <= 1'b1;
      if (enter_resp) begin
        if (op_wr_reg) begin
          write_count <= write_count + 32'd1;
        end else begin
          read_count     <= read_count + 32'd1;
          bus.pmem_rdata <= mem[idx_reg];
        end
      end
    end
  end

  // Line store write port; a reset before the RESP edge cancels the write.
  always_ff @(posedge clk) begin
    if (enter_resp && op_wr_reg && !rst) mem[idx_reg] <= wdata_reg;
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a vector table of transactions on a
// LAT=10 instance, plus reset-mid-operation, operand-change and LAT=1
// held-request sequences.
module tb_pmem_responder;

  localparam logic [255:0] DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] P1 = {4{64'hA5A5_0000_1111_2222}};
  localparam logic [255:0] P2 = {8{32'h0BAD_F00D}};
  localparam logic [255:0] PB = {16{16'hB00B}};
  localparam logic [255:0] PA = {16{16'hAAAA}};

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_rdata;
    logic         exp_perr;
    logic [31:0]  exp_rc;
    logic [31:0]  exp_wc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_if bus_a();
  pmem_if bus_b();
  logic        perr_a, perr_b;
  logic [31:0] rc_a, wc_a, rc_b, wc_b;

  pmem_responder #(.IDX_BITS(8), .READ_LAT(10), .WRITE_LAT(10)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .protocol_error(perr_a), .read_count(rc_a), .write_count(wc_a)
  );

  pmem_responder #(.IDX_BITS(8), .READ_LAT(1), .WRITE_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .protocol_error(perr_b), .read_count(rc_b), .write_count(wc_b)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs [9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE, returns at the negedge of the IDLE cycle
  // after RESP. lat = cycle index of resp after the accepting edge, -1 on timeout.
  task automatic run_a(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wd, input bit perturb, output int lat);
    bus_a.pmem_read  = rd;
    bus_a.pmem_write = wr;
    bus_a.pmem_addr  = addr;
    bus_a.pmem_wdata = wd;
    @(posedge clk);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (perturb && n == 3) begin
        bus_a.pmem_addr  = addr + 32'h20;
        bus_a.pmem_wdata = ~wd;
        bus_a.pmem_write = 1'b0;
        bus_a.pmem_read  = 1'b0;
      end
      if (bus_a.pmem_resp) begin
        lat = n;
        break;
      end
    end
    bus_a.pmem_read  = 1'b0;
    bus_a.pmem_write = 1'b0;
    @(negedge clk);
    check("resp_single_pulse", {255'd0, bus_a.pmem_resp}, 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic [5:0] pat;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, DB,     256'd0, 1'b0, 32'd0, 32'd1};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 256'd0, DB,     1'b0, 32'd1, 32'd1};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0020, P1,     DB,     1'b0, 32'd1, 32'd2};
    vecs[3] = '{1'b1, 1'b0, 32'h1000_003F, 256'd0, P1,     1'b0, 32'd2, 32'd2};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 256'd0, DB,     1'b0, 32'd3, 32'd2};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0060, P2,     DB,     1'b1, 32'd3, 32'd3};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0060, 256'd0, P2,     1'b1, 32'd4, 32'd3};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0080, PB,     P2,     1'b1, 32'd4, 32'd4};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0080, 256'd0, PB,     1'b1, 32'd5, 32'd4};

    rst = 1'b1;
    bus_a.pmem_read = 1'b0; bus_a.pmem_write = 1'b0; bus_a.pmem_addr = '0; bus_a.pmem_wdata = '0;
    bus_b.pmem_read = 1'b0; bus_b.pmem_write = 1'b0; bus_b.pmem_addr = '0; bus_b.pmem_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_resp",  {255'd0, bus_a.pmem_resp}, 256'd0);
    check("reset_rdata", bus_a.pmem_rdata, 256'd0);
    check("reset_perr",  {255'd0, perr_a}, 256'd0);
    check("reset_rc",    {224'd0, rc_a}, 256'd0);
    check("reset_wc",    {224'd0, wc_a}, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_a(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, lat);
      $display("txn %0d rd=%0b wr=%0b addr=%h lat=%0d rc=%0d wc=%0d perr=%0b",
               i, vecs[i].rd, vecs[i].wr, vecs[i].addr, lat, rc_a, wc_a, perr_a);
      check("vec_latency", 256'(lat), 256'd10);
      check("vec_rdata", bus_a.pmem_rdata, vecs[i].exp_rdata);
      check("vec_perr", {255'd0, perr_a}, {255'd0, vecs[i].exp_perr});
      check("vec_read_count", {224'd0, rc_a}, {224'd0, vecs[i].exp_rc});
      check("vec_write_count", {224'd0, wc_a}, {224'd0, vecs[i].exp_wc});
    end

    // Reset during BUSY of a write to 0x80 (which holds PB).
    bus_a.pmem_write = 1'b1;
    bus_a.pmem_addr  = 32'h0000_0080;
    bus_a.pmem_wdata = PA;
    @(posedge clk);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus_a.pmem_resp) seen++;
      if (n == 4) begin
        rst = 1'b1;
        bus_a.pmem_write = 1'b0;
      end
      if (n == 6) rst = 1'b0;
    end
    $display("txn reset_mid_write resp_pulses=%0d rc=%0d wc=%0d perr=%0b", seen, rc_a, wc_a, perr_a);
    check("rst_mid_no_resp", 256'(seen), 256'd0);
    check("rst_mid_rc", {224'd0, rc_a}, 256'd0);
    check("rst_mid_wc", {224'd0, wc_a}, 256'd0);
    check("rst_mid_perr", {255'd0, perr_a}, 256'd0);
    check("rst_mid_rdata", bus_a.pmem_rdata, 256'd0);
    run_a(1'b1, 1'b0, 32'h0000_0080, 256'd0, 1'b0, lat);
    $display("txn read_after_reset addr=00000080 lat=%0d", lat);
    check("rst_read_latency", 256'(lat), 256'd10);
    check("rst_read_old_line", bus_a.pmem_rdata, PB);
    check("rst_read_rc", {224'd0, rc_a}, 256'd1);

    // Operands change and the request drops while BUSY.
    run_a(1'b0, 1'b1, 32'h0000_0100, PA, 1'b1, lat);
    $display("txn perturbed_write addr=00000100 lat=%0d wc=%0d", lat, wc_a);
    check("perturb_latency", 256'(lat), 256'd10);
    check("perturb_wc", {224'd0, wc_a}, 256'd1);
    run_a(1'b1, 1'b0, 32'h0000_0100, 256'd0, 1'b0, lat);
    $display("txn read_perturbed addr=00000100 lat=%0d", lat);
    check("perturb_read_line", bus_a.pmem_rdata, PA);
    check("perturb_read_rc", {224'd0, rc_a}, 256'd2);

    // LAT=1 instance: write, then a read held high across two completions.
    bus_b.pmem_write = 1'b1;
    bus_b.pmem_addr  = 32'h0000_0020;
    bus_b.pmem_wdata = P2;
    @(posedge clk);
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus_b.pmem_resp) begin
        lat = n;
        break;
      end
    end
    bus_b.pmem_write = 1'b0;
    @(negedge clk);
    $display("txn lat1_write addr=00000020 lat=%0d", lat);
    check("lat1_write_latency", 256'(lat), 256'd1);

    bus_b.pmem_read = 1'b1;
    bus_b.pmem_addr = 32'h0000_0020;
    @(posedge clk);
    pat = '0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      pat[n] = bus_b.pmem_resp;
    end
    bus_b.pmem_read = 1'b0;
    @(negedge clk);
    $display("txn lat1_held_read resp_pattern=%b rc=%0d", pat, rc_b);
    check("lat1_held_resp_pattern", {250'd0, pat}, {250'd0, 6'b010010});
    check("lat1_read_rdata", bus_b.pmem_rdata, P2);
    check("lat1_read_count", {224'd0, rc_b}, 256'd2);
    check("lat1_write_count", {224'd0, wc_b}, 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
